grid_walk_ctrl: RTL
===================

# grid_walk_ctrl

Sequential controller for the grid-walk datapath. It holds the walker's X/Y position, accepts move commands over a valid/ready handshake, and forms each next coordinate with a 5-bit add/subtract of a 2-bit step. It performs the wall (bounds) check, then commits or rejects the move and reports the result. The 5-bit add/subtract stage sits directly downstream of this block and is driven by it; the implementation may instantiate the existing 5-bit adder/subtractor for that arithmetic.

## Interface
- GRID_MAX, 15: largest legal coordinate on both axes; legal range 0..GRID_MAX; must be 1..15.
- START_X, 0: X after reset; must be ≤ GRID_MAX.
- START_Y, 0: Y after reset; must be ≤ GRID_MAX.
- GOAL_X, 15: goal X.
- GOAL_Y, 15: goal Y.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_dir  in  2  direction: 00 = +X, 01 = −X, 10 = +Y, 11 = −Y.
- cmd_step  in  2  step size, 0..3.
- pos_x  out  5  current X (unsigned).
- pos_y  out  5  current Y (unsigned).
- resp_valid  out  1  one-cycle pulse when a command completes.
- resp_wall  out  1  qualified by resp_valid: 1 = move rejected, position unchanged.
- at_goal  out  1  high whenever pos_x == GOAL_X and pos_y == GOAL_Y.
- move_count  out  8  number of committed moves, saturating at 255.

## Operation
- States and transitions:
  - IDLE: cmd_ready = 1. On cmd_valid, the command is accepted; go to EXEC.
  - EXEC: compute, check, and conditionally commit; go to RESP.
  - RESP: resp_valid = 1; go to IDLE.
- On acceptance, capture cmd_dir and cmd_step. Inputs are ignored outside IDLE.
- In EXEC:
  - Operand is pos_x when dir[1] = 0, otherwise pos_y.
  - Operation is add when dir[0] = 0, subtract when dir[0] = 1.
  - Result is operand ± {3'b000, step}, 5 bits wide.
- Legality:
  - Add is legal iff the result, read as unsigned, is ≤ GRID_MAX. With a maximum of 15 + 3 = 18 there is no 5-bit wrap.
  - Subtract is legal iff result[4] == 0. A negative result sets the sign bit.
  - step = 0 is always legal. It commits with no change and increments move_count.
- Commit:
  - On a legal move, write the result to the selected axis at the EXEC→RESP edge, increment move_count (saturating), and register resp_wall = 0.
  - On an illegal move, leave the position and count unchanged and register resp_wall = 1.
- resp_wall holds its value outside RESP. Consumers sample it only when resp_valid = 1.
- at_goal is combinational from the position registers. Commands remain accepted while at_goal is high.

## Timing
- Reset values:
  - pos_x = START_X, pos_y = START_Y, move_count = 0, resp_valid = 0, resp_wall = 0.
  - State is IDLE.
  - cmd_ready = 0 while reset is high; cmd_ready = 1 in the first cycle after reset deasserts.
- Latency: a command accepted at edge T produces RESP (resp_valid = 1) in cycle T+2. The new position is visible in that same cycle. cmd_ready returns high in cycle T+3.
- Throughput: one command per 3 cycles. cmd_ready is low in EXEC and RESP.
- cmd_valid held high continuously: the next command is accepted at the first IDLE cycle. No command is dropped and none is duplicated.
- Reset in EXEC or RESP: the command is abandoned and no resp_valid is issued. The position returns to START_X/START_Y even if the commit had already occurred.
- Edges:
  - Landing exactly on GRID_MAX or on 0 is legal.
  - One past either bound is a wall.
  - move_count stays at 255 once reached.

## Test plan
- Reset with START=(0,0), then +X step 3 → resp_valid exactly 2 cycles after acceptance, resp_wall = 0, pos_x = 3, move_count = 1; cmd_ready low for 2 cycles.
- From (0,0), −Y step 1 → resp_wall = 1, pos_y = 0, move_count unchanged. Then from pos_x = 14 with GRID_MAX = 15, +X step 2 → wall; +X step 1 → pos_x = 15, legal.
- Walk +X 3,3,3,3,3 (x = 15), then +Y five steps of 3 → at_goal rises in the RESP cycle of the final move; a further +X step 1 is a wall and at_goal stays high.
- Hold cmd_valid high for 10 back-to-back commands → exactly 10 resp_valid pulses, spaced 3 cycles apart; move_count = 10 (if none hit a wall).
- Assert reset during EXEC of a +X step 2 from x = 5 → no resp_valid; pos_x = START_X; cmd_ready is 1 in the cycle after reset deasserts.
- Issue 300 step-0 commands → move_count saturates at 255; position unchanged; every response has resp_wall = 0.

Source files
------------

// File: rtl/grid_walk_ctrl.sv
// Grid-walk controller: accepts a move command, forms the next coordinate with a
// 5-bit add/subtract, performs the wall check, and commits or rejects the move.
//
// state  | meaning
// S_IDLE | ready for a command; cmd_ready high
// S_EXEC | compute, bounds-check, and commit on a legal move
// S_RESP | one-cycle response; resp_valid high
module grid_walk_ctrl #(
    parameter int GRID_MAX = 15,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int GOAL_X   = 15,
    parameter int GOAL_Y   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_dir,
    input  logic [1:0] cmd_step,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic       resp_valid,
    output logic       resp_wall,
    output logic       at_goal,
    output logic [7:0] move_count
);

    localparam logic [4:0] GRID_MAX_V = 5'(GRID_MAX);
    localparam logic [4:0] START_X_V  = 5'(START_X);
    localparam logic [4:0] START_Y_V  = 5'(START_Y);
    localparam logic [4:0] GOAL_X_V   = 5'(GOAL_X);
    localparam logic [4:0] GOAL_Y_V   = 5'(GOAL_Y);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] dir_q;
    logic [1:0] step_q;
    logic [4:0] operand;
    logic [4:0] result;
    logic       legal;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gated with reset so a reset landing in RESP never shows a response.
    always_comb begin
        cmd_ready  = (state == S_IDLE) && !reset;
        resp_valid = (state == S_RESP) && !reset;
    end

    // Operands stay below 16 and steps below 4, so an add cannot wrap and a
    // negative subtract result always sets bit 4.
    always_comb begin
        operand = dir_q[1] ? pos_y : pos_x;
        result  = dir_q[0] ? (operand - {3'b000, step_q}) : (operand + {3'b000, step_q});
        legal   = dir_q[0] ? !result[4] : (result <= GRID_MAX_V);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x      <= START_X_V;
            pos_y      <= START_Y_V;
            move_count <= 8'd0;
            resp_wall  <= 1'b0;
            dir_q      <= 2'd0;
            step_q     <= 2'd0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                dir_q  <= cmd_dir;
                step_q <= cmd_step;
            end
            if (state == S_EXEC) begin
                resp_wall <= !legal;
                if (legal) begin
                    if (dir_q[1]) pos_y <= result;
                    else          pos_x <= result;
                    if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                end
            end
        end
    end

    assign at_goal = (pos_x == GOAL_X_V) && (pos_y == GOAL_Y_V);

endmodule
